// File: rtl/adder_bank_sched_pkg.sv
// Shared types and defaults for the adder bank scheduler.
// State encoding, default geometry and pipeline depth helper.
package adder_bank_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CHECK,
    DONE
  } state_t;

  localparam int DEF_NBLK     = 8;
  localparam int DEF_NLAYER   = 4;
  localparam int DEF_MAX_ITER = 8;
  localparam int DEF_RD_LAT   = 1;
  localparam int DEF_ADD_LAT  = 1;

  function automatic int pipe_depth(
    input int rd_lat,
    input int add_lat
  );
    return rd_lat + add_lat;
  endfunction

endpackage

// File: rtl/adder_bank_sched_delay_line.sv
// Depth-PIPE shift register of {valid, addr} with sync clear.
// Aligns write-back strobes with the read/adder pipeline.
module sched_delay_line #(
  parameter int DEPTH = 2,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  output logic          o_valid,
  output logic [AW-1:0] o_addr
);

  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_addr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_addr[0]  <= i_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_addr  = r_addr[DEPTH-1];

endmodule

// File: rtl/adder_bank_sched.sv
// Layered LDPC decode-loop sequencer for the adder bank.
// Define ADDER_SCHED_EARLY_TERM_EN to stop on parity success.
module adder_bank_sched
  import adder_bank_sched_pkg::*;
#(
  parameter int NBLK     = DEF_NBLK,
  parameter int NLAYER   = DEF_NLAYER,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int RD_LAT   = DEF_RD_LAT,
  parameter int ADD_LAT  = DEF_ADD_LAT,
  parameter int BW       = $clog2(NBLK),
  parameter int LW       = $clog2(NLAYER),
  parameter int IW       = $clog2(MAX_ITER) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          parity_ok,
  output logic          rd_en,
  output logic [BW-1:0] rd_addr,
  output logic [LW-1:0] layer,
  output logic          first_iter,
  output logic          wr_en,
  output logic [BW-1:0] wr_addr,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic [IW-1:0] iter_cnt
);

  localparam int PIPE = pipe_depth(RD_LAT, ADD_LAT);
  localparam int DW   = (PIPE > 1) ? $clog2(PIPE) : 1;

  localparam logic [BW-1:0] LAST_BLK = BW'(NBLK - 1);
  localparam logic [LW-1:0] LAST_LYR = LW'(NLAYER - 1);
  localparam logic [IW-1:0] LAST_IT  = IW'(MAX_ITER - 1);
  localparam logic [DW-1:0] LAST_DRN = DW'(PIPE - 1);

  state_t        r_state;
  state_t        w_next;
  logic [BW-1:0] r_rd_addr;
  logic [DW-1:0] r_dcnt;
  logic [LW-1:0] r_layer;
  logic [IW-1:0] r_iter;
  logic          r_conv;

  logic w_flush;
  logic w_go;
  logic w_last_blk;
  logic w_last_drn;
  logic w_last_lyr;
  logic w_term;
  logic w_conv_nxt;

  assign w_flush    = abort && (r_state != IDLE);
  assign w_go       = start && !abort;
  assign w_last_blk = (r_rd_addr == LAST_BLK);
  assign w_last_drn = (r_dcnt == LAST_DRN);
  assign w_last_lyr = (r_layer == LAST_LYR);

`ifdef ADDER_SCHED_EARLY_TERM_EN
  assign w_term     = (r_iter == LAST_IT) || parity_ok;
  assign w_conv_nxt = parity_ok;
`else
  logic w_unused_parity;
  assign w_unused_parity = parity_ok;
  assign w_term          = (r_iter == LAST_IT);
  assign w_conv_nxt      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_go) w_next = ISSUE;
      end
      ISSUE: begin
        if (abort)           w_next = IDLE;
        else if (w_last_blk) w_next = DRAIN;
      end
      DRAIN: begin
        if (abort)           w_next = IDLE;
        else if (w_last_drn) w_next = w_last_lyr ? CHECK : ISSUE;
      end
      CHECK: begin
        if (abort)       w_next = IDLE;
        else if (w_term) w_next = DONE;
        else             w_next = ISSUE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    unique case (r_state)
      IDLE:    busy  = 1'b0;
      ISSUE:   rd_en = 1'b1;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  // Abort leaves layer/iter visible; the next start clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_dcnt    <= '0;
      r_layer   <= '0;
      r_iter    <= '0;
      r_conv    <= 1'b0;
    end else if (w_flush) begin
      r_rd_addr <= '0;
      r_dcnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_go) begin
            r_rd_addr <= '0;
            r_dcnt    <= '0;
            r_layer   <= '0;
            r_iter    <= '0;
            r_conv    <= 1'b0;
          end
        end
        ISSUE: begin
          if (w_last_blk) r_rd_addr <= '0;
          else            r_rd_addr <= r_rd_addr + BW'(1);
        end
        DRAIN: begin
          if (w_last_drn) begin
            r_dcnt <= '0;
            if (!w_last_lyr) r_layer <= r_layer + LW'(1);
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        CHECK: begin
          if (w_term) begin
            r_conv <= w_conv_nxt;
          end else begin
            r_iter  <= r_iter + IW'(1);
            r_layer <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  sched_delay_line #(
    .DEPTH (PIPE),
    .AW    (BW)
  ) u_wb_dly (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_flush),
    .i_valid (rd_en),
    .i_addr  (r_rd_addr),
    .o_valid (wr_en),
    .o_addr  (wr_addr)
  );

  assign rd_addr    = r_rd_addr;
  assign layer      = r_layer;
  assign iter_cnt   = r_iter;
  assign converged  = r_conv;
  assign first_iter = (r_iter == '0);

endmodule

// File: tb/tb_adder_bank_sched.sv
// Directed self-checking bench for adder_bank_sched.
// Default instance plus a small-geometry parameter instance.
module tb_adder_bank_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       parity_ok;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic [1:0] layer;
  logic       first_iter;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic       busy;
  logic       done;
  logic       converged;
  logic [3:0] iter_cnt;

  logic       s_start;
  logic       s_abort;
  logic       s_par;
  logic       s_rd_en;
  logic [1:0] s_rd_addr;
  logic [0:0] s_layer;
  logic       s_first;
  logic       s_wr_en;
  logic [1:0] s_wr_addr;
  logic       s_busy;
  logic       s_done;
  logic       s_conv;
  logic [0:0] s_iter;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_bank_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .parity_ok  (parity_ok),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .layer      (layer),
    .first_iter (first_iter),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy),
    .done       (done),
    .converged  (converged),
    .iter_cnt   (iter_cnt)
  );

  adder_bank_sched #(
    .NBLK     (4),
    .NLAYER   (2),
    .MAX_ITER (1),
    .RD_LAT   (1),
    .ADD_LAT  (3),
    .BW       (2),
    .LW       (1),
    .IW       (1)
  ) dut_s (
    .clk        (clk),
    .rst        (rst),
    .start      (s_start),
    .abort      (s_abort),
    .parity_ok  (s_par),
    .rd_en      (s_rd_en),
    .rd_addr    (s_rd_addr),
    .layer      (s_layer),
    .first_iter (s_first),
    .wr_en      (s_wr_en),
    .wr_addr    (s_wr_addr),
    .busy       (s_busy),
    .done       (s_done),
    .converged  (s_conv),
    .iter_cnt   (s_iter)
  );

  // Default geometry: 41-cycle iteration, 10-cycle layer, 8 reads.
  function automatic bit m_rd(input int c);
    int pos;
    if (c < 1 || c > 328) return 1'b0;
    pos = (c - 1) % 41;
    if (pos == 40) return 1'b0;
    return ((pos % 10) < 8);
  endfunction

  function automatic int m_addr(input int c);
    return ((c - 1) % 41) % 10;
  endfunction

  // Small geometry: 8-cycle layer, 4 reads, 2 layers, 1 iteration.
  function automatic bit s_m_rd(input int c);
    if (c < 1 || c > 16) return 1'b0;
    return (((c - 1) % 8) < 4);
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; parity_ok = 1'b0;
    s_start = 1'b0; s_abort = 1'b0; s_par = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rd_en, wr_en, busy, done, converged, first_iter} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000001",
               {rd_en, wr_en, busy, done, converged, first_iter});
    end
    n_checks++;
    if ({rd_addr, wr_addr, layer, iter_cnt} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %h want 000",
               {rd_addr, wr_addr, layer, iter_cnt});
    end
    n_checks++;
    if ({s_rd_en, s_wr_en, s_busy, s_done, s_conv, s_first} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_sweep_flags: got %b want 000001",
               {s_rd_en, s_wr_en, s_busy, s_done, s_conv, s_first});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  // Full default decode; dup_c>0 adds an ignored start while busy.
  task automatic run_full(input logic par, input int dup_c,
                          input string tag);
    bit er;
    bit ew;
    int el;
    int ei;
    int nrd;
    nrd = 0;
    parity_ok = par;
    pulse_start();
    for (int c = 1; c <= 329; c++) begin
      er = m_rd(c);
      ew = m_rd(c - 2);
      ei = (c >= 329) ? 7 : (c - 1) / 41;
      el = (((c - 1) % 41) == 40) ? 3 : ((c - 1) % 41) / 10;
      n_checks++;
      if (rd_en !== er) begin
        n_fail++;
        $display("FAIL %s rd_en c=%0d: got %b want %b", tag, c, rd_en, er);
      end
      if (er) begin
        n_checks++;
        if (rd_addr !== 3'(m_addr(c))) begin
          n_fail++;
          $display("FAIL %s rd_addr c=%0d: got %0d want %0d",
                   tag, c, rd_addr, m_addr(c));
        end
      end
      n_checks++;
      if (wr_en !== ew) begin
        n_fail++;
        $display("FAIL %s wr_en c=%0d: got %b want %b", tag, c, wr_en, ew);
      end
      if (ew) begin
        n_checks++;
        if (wr_addr !== 3'(m_addr(c - 2))) begin
          n_fail++;
          $display("FAIL %s wr_addr c=%0d: got %0d want %0d",
                   tag, c, wr_addr, m_addr(c - 2));
        end
      end
      if (c <= 328) begin
        n_checks++;
        if (layer !== 2'(el)) begin
          n_fail++;
          $display("FAIL %s layer c=%0d: got %0d want %0d",
                   tag, c, layer, el);
        end
      end
      n_checks++;
      if (iter_cnt !== 4'(ei) || first_iter !== (ei == 0)) begin
        n_fail++;
        $display("FAIL %s iter c=%0d: got %0d/%b want %0d/%b",
                 tag, c, iter_cnt, first_iter, ei, (ei == 0));
      end
      n_checks++;
      if (busy !== 1'b1 || done !== (c == 329)) begin
        n_fail++;
        $display("FAIL %s busy_done c=%0d: got %b%b want 1%b",
                 tag, c, busy, done, (c == 329));
      end
      if (rd_en === 1'b1) nrd++;
      if (c == 329) begin
        n_checks++;
        if (converged !== 1'b0 || nrd != 256) begin
          n_fail++;
          $display("FAIL %s end: got conv=%b reads=%0d want 0/256",
                   tag, converged, nrd);
        end
      end
      start = (c == dup_c);
      @(negedge clk);
    end
    start = 1'b0;
    parity_ok = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post_done: got busy=%b done=%b want 0/0",
               tag, busy, done);
    end
  endtask

`ifdef ADDER_SCHED_EARLY_TERM_EN
  task automatic test_early_term();
    parity_ok = 1'b1;
    pulse_start();
    for (int c = 1; c <= 42; c++) begin
      n_checks++;
      if (first_iter !== 1'b1 || busy !== 1'b1 || done !== (c == 42)) begin
        n_fail++;
        $display("FAIL early c=%0d: got fi=%b busy=%b done=%b want 1/1/%b",
                 c, first_iter, busy, done, (c == 42));
      end
      if (c == 42) begin
        n_checks++;
        if (iter_cnt !== 4'd0 || converged !== 1'b1) begin
          n_fail++;
          $display("FAIL early_end: got iter=%0d conv=%b want 0/1",
                   iter_cnt, converged);
        end
      end
      @(negedge clk);
    end
    parity_ok = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || converged !== 1'b1) begin
      n_fail++;
      $display("FAIL early_hold: got busy=%b conv=%b want 0/1",
               busy, converged);
    end
  endtask
`else
  task automatic test_parity_ignored();
    run_full(1'b1, 0, "noet");
  endtask
`endif

  task automatic test_abort();
    int nbad;
    nbad = 0;
    pulse_start();
    repeat (23) @(negedge clk);
    n_checks++;
    if ({layer, rd_addr, rd_en} !== {2'd2, 3'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_pos: got L%0d A%0d rd=%b want L2 A3 rd=1",
               layer, rd_addr, rd_en);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({busy, rd_en, wr_en, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_idle: got %b want 0000",
               {busy, rd_en, wr_en, done});
    end
    for (int i = 0; i < 20; i++) begin
      if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) nbad++;
      @(negedge clk);
    end
    n_checks++;
    if (nbad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", nbad);
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_vs_start: got busy=%b want 0", busy);
    end
    pulse_start();
    n_checks++;
    if ({rd_en, layer, rd_addr, iter_cnt} !== {1'b1, 2'd0, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL abort_restart: got rd=%b L%0d A%0d I%0d want 1/0/0/0",
               rd_en, layer, rd_addr, iter_cnt);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_busy_start();
    run_full(1'b0, 5, "dupstart");
  endtask

  task automatic test_rst_drain();
    pulse_start();
    repeat (8) @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b0 || busy !== 1'b1 || wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_state: got rd=%b busy=%b wr=%b want 0/1/1",
               rd_en, busy, wr_en);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({rd_en, wr_en, busy, done, converged, first_iter} !== 6'b000001 ||
        {rd_addr, wr_addr, layer, iter_cnt} !== 12'd0) begin
      n_fail++;
      $display("FAIL drain_reset: got %b/%h want 000001/000",
               {rd_en, wr_en, busy, done, converged, first_iter},
               {rd_addr, wr_addr, layer, iter_cnt});
    end
  endtask

  task automatic test_sweep();
    bit er;
    bit ew;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      er = s_m_rd(c);
      ew = s_m_rd(c - 4);
      n_checks++;
      if (s_rd_en !== er || s_wr_en !== ew) begin
        n_fail++;
        $display("FAIL sweep_rw c=%0d: got %b%b want %b%b",
                 c, s_rd_en, s_wr_en, er, ew);
      end
      if (ew) begin
        n_checks++;
        if (s_wr_addr !== 2'((c - 5) % 8)) begin
          n_fail++;
          $display("FAIL sweep_wr_addr c=%0d: got %0d want %0d",
                   c, s_wr_addr, (c - 5) % 8);
        end
      end
      n_checks++;
      if (s_done !== (c == 18) || s_busy !== (c <= 18)) begin
        n_fail++;
        $display("FAIL sweep_done c=%0d: got d=%b b=%b want %b/%b",
                 c, s_done, s_busy, (c == 18), (c <= 18));
      end
      if (c == 18) begin
        n_checks++;
        if (s_iter !== 1'b0 || s_conv !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_end: got iter=%0d conv=%b want 0/0",
                   s_iter, s_conv);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
`ifdef ADDER_SCHED_EARLY_TERM_EN
    test_early_term();
`else
    test_parity_ignored();
`endif
    run_full(1'b0, 0, "basic");
    test_abort();
    test_busy_start();
    test_rst_drain();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
